// File: rtl/byte_pack_fifo_if.sv
// byte_pack_fifo_if: packed-word stream from byte_pack_fifo to its sink.
// master = word producer (FIFO head), slave = consumer (bus/DMA writer).
interface byte_pack_fifo_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_ts;
  logic        word_last;
  logic [1:0]  word_nbytes;

  modport master (
    output word_valid, word_data, word_ts, word_last, word_nbytes,
    input  word_ready
  );

  modport slave (
    input  word_valid, word_data, word_ts, word_last, word_nbytes,
    output word_ready
  );
endinterface

// File: rtl/byte_pack_fifo.sv
// byte_pack_fifo: packs timeslot bytes into 32-bit words (first byte in [7:0]),
// tags them with timeslot / end-of-window / byte count and buffers them in a
// show-ahead FIFO. Optional statistics counters: define BYTE_PACK_STAT_EN.
module byte_pack_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             byte_sync,
  input  logic [7:0]       byte_data,
  input  logic             byte_win0,
  input  logic             byte_win1,
  input  logic             ovf_clr,
  byte_pack_fifo_if.master word_if,
  output logic [LVL_W-1:0] fifo_level,
  output logic             ovf_flag,
  output logic [15:0]      word_cnt0,
  output logic [15:0]      word_cnt1,
  output logic [15:0]      drop_cnt
);
  localparam int AW = LVL_W - 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  logic [1:0]  win_cur;
  logic [1:0]  win_q_reg;
  logic [1:0]  close_ts;
  logic [31:0] pack_data_reg, pack_data_next;
  logic [1:0]  pack_cnt_reg, pack_cnt_next;
  logic        pack_ts_reg, pack_ts_next;
  logic        pend_v_reg, pend_v_next;
  logic [31:0] pend_data_reg, pend_data_next;
  logic        byte_acc, byte_ts, has_data, flush;
  logic        push;
  logic [35:0] push_entry;

  assign win_cur  = {byte_win1, byte_win0};
  assign byte_acc = byte_sync & (byte_win0 | byte_win1);
  assign byte_ts  = ~byte_win0;  // ts0 wins when both windows are high
  assign has_data = pend_v_reg | (pack_cnt_reg != 2'd0);

  // A window closes on its falling edge, but only if it owns the held data
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_close
      assign close_ts[gi] = win_q_reg[gi] & ~win_cur[gi] & (pack_ts_reg == (gi == 1));
    end
  endgenerate

  // A byte from the other timeslot also terminates the held window
  assign flush = (|close_ts) | (byte_acc & (byte_ts != pack_ts_reg) & has_data);

  // Pack / pending next state and the single per-cycle push request
  always_comb begin
    pack_data_next = pack_data_reg;
    pack_cnt_next  = pack_cnt_reg;
    pack_ts_next   = pack_ts_reg;
    pend_v_next    = pend_v_reg;
    pend_data_next = pend_data_reg;
    push           = 1'b0;
    push_entry     = 36'h0;
    if (flush) begin
      if (pend_v_reg) begin
        push       = 1'b1;
        push_entry = {pack_ts_reg, 1'b1, 2'd3, pend_data_reg};
      end else if (pack_cnt_reg != 2'd0) begin
        push       = 1'b1;
        push_entry = {pack_ts_reg, 1'b1, pack_cnt_reg - 2'd1, pack_data_reg};
      end
      pend_v_next    = 1'b0;
      pend_data_next = 32'h0;
      pack_cnt_next  = 2'd0;
      pack_data_next = 32'h0;
    end else if (byte_acc && pend_v_reg) begin
      // More data in the same window: the pending word was not the last one
      push           = 1'b1;
      push_entry     = {pack_ts_reg, 1'b0, 2'd3, pend_data_reg};
      pend_v_next    = 1'b0;
      pend_data_next = 32'h0;
    end
    if (byte_acc) begin
      pack_ts_next = byte_ts;
      if (pack_cnt_next == 2'd3) begin
        pend_v_next    = 1'b1;
        pend_data_next = {byte_data, pack_data_next[23:0]};
        pack_cnt_next  = 2'd0;
        pack_data_next = 32'h0;
      end else begin
        pack_data_next = pack_data_next | ({24'h0, byte_data} << {pack_cnt_next, 3'b000});
        pack_cnt_next  = pack_cnt_next + 2'd1;
      end
    end
  end

  // Pack, pending and window-history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q_reg     <= 2'b00;
      pack_data_reg <= 32'h0;
      pack_cnt_reg  <= 2'd0;
      pack_ts_reg   <= 1'b0;
      pend_v_reg    <= 1'b0;
      pend_data_reg <= 32'h0;
    end else begin
      win_q_reg     <= win_cur;
      pack_data_reg <= pack_data_next;
      pack_cnt_reg  <= pack_cnt_next;
      pack_ts_reg   <= pack_ts_next;
      pend_v_reg    <= pend_v_next;
      pend_data_reg <= pend_data_next;
    end
  end

  logic [35:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [35:0]      head;
  logic             full, pop, push_ok, drop;

  assign full    = (level_reg == DEPTH_LVL);
  assign pop     = word_if.word_valid & word_if.word_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign head    = mem[rd_ptr_reg];

  // Storage array; contents need no reset since level gates the outputs
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_entry;
  end

  // Pointers, occupancy and sticky overflow flag (drop beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop)         ovf_flag <= 1'b1;
      else if (ovf_clr) ovf_flag <= 1'b0;
    end
  end

  assign fifo_level          = level_reg;
  assign word_if.word_valid  = (level_reg != '0);
  assign word_if.word_data   = word_if.word_valid ? head[31:0]  : 32'h0;
  assign word_if.word_nbytes = word_if.word_valid ? head[33:32] : 2'd0;
  assign word_if.word_last   = word_if.word_valid & head[34];
  assign word_if.word_ts     = word_if.word_valid & head[35];

`ifdef BYTE_PACK_STAT_EN
  logic [15:0] cnt0_reg, cnt1_reg, drop_reg;

  // Saturating push/drop statistics, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_reg <= 16'h0;
      cnt1_reg <= 16'h0;
      drop_reg <= 16'h0;
    end else begin
      if (push_ok && !push_entry[35] && cnt0_reg != 16'hFFFF) cnt0_reg <= cnt0_reg + 16'd1;
      if (push_ok &&  push_entry[35] && cnt1_reg != 16'hFFFF) cnt1_reg <= cnt1_reg + 16'd1;
      if (drop && drop_reg != 16'hFFFF)                       drop_reg <= drop_reg + 16'd1;
    end
  end

  assign word_cnt0 = cnt0_reg;
  assign word_cnt1 = cnt1_reg;
  assign drop_cnt  = drop_reg;
`else
  assign word_cnt0 = 16'h0;
  assign word_cnt1 = 16'h0;
  assign drop_cnt  = 16'h0;
`endif
endmodule

// File: tb/tb_byte_pack_fifo.sv
// tb_byte_pack_fifo: directed checks of byte packing, window close handling,
// FIFO overflow / full-with-pop behaviour and mid-window reset.
module tb_byte_pack_fifo;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        byte_sync;
  logic [7:0]  byte_data;
  logic        byte_win0;
  logic        byte_win1;
  logic        ovf_clr;
  logic [4:0]  fifo_level;
  logic        ovf_flag;
  logic [15:0] word_cnt0, word_cnt1, drop_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  byte_pack_fifo_if wif ();

  byte_pack_fifo #(.FIFO_DEPTH(16), .LVL_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_sync  (byte_sync),
    .byte_data  (byte_data),
    .byte_win0  (byte_win0),
    .byte_win1  (byte_win1),
    .ovf_clr    (ovf_clr),
    .word_if    (wif),
    .fifo_level (fifo_level),
    .ovf_flag   (ovf_flag),
    .word_cnt0  (word_cnt0),
    .word_cnt1  (word_cnt1),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic byte_in(input logic [7:0] d, input logic w0, input logic w1);
    byte_sync = 1'b1;
    byte_data = d;
    byte_win0 = w0;
    byte_win1 = w1;
    tick();
    byte_sync = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] d, input logic ts,
                          input logic last, input logic [1:0] nb);
    chk({tag, "_valid"}, 36'(wif.word_valid), 36'(1'b1));
    chk({tag, "_data"},  36'(wif.word_data), 36'(d));
    chk({tag, "_ts"},    36'(wif.word_ts), 36'(ts));
    chk({tag, "_last"},  36'(wif.word_last), 36'(last));
    chk({tag, "_nb"},    36'(wif.word_nbytes), 36'(nb));
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] dr);
`ifdef BYTE_PACK_STAT_EN
    chk({tag, "_cnt0"}, 36'(word_cnt0), 36'(c0));
    chk({tag, "_cnt1"}, 36'(word_cnt1), 36'(c1));
    chk({tag, "_drop"}, 36'(drop_cnt), 36'(dr));
`else
    chk({tag, "_cnt0"}, 36'(word_cnt0), 36'(16'h0 & c0));
    chk({tag, "_cnt1"}, 36'(word_cnt1), 36'(16'h0 & c1));
    chk({tag, "_drop"}, 36'(drop_cnt), 36'(16'h0 & dr));
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 36'(wif.word_valid), 36'(1'b0));
    chk({tag, "_level"}, 36'(fifo_level), 36'(5'd0));
    chk({tag, "_data"},  36'(wif.word_data), 36'(32'h0));
    chk({tag, "_flags"}, 36'({wif.word_ts, wif.word_last, wif.word_nbytes}), 36'(4'h0));
  endtask

  initial begin
    logic [31:0] exp_w;
    reset_n        = 1'b0;
    byte_sync      = 1'b0;
    byte_data      = 8'h0;
    byte_win0      = 1'b0;
    byte_win1      = 1'b0;
    ovf_clr        = 1'b0;
    wif.word_ready = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_ovf", 36'(ovf_flag), 36'(1'b0));
    chk_stats("rst", 16'd0, 16'd0, 16'd0);
    reset_n = 1'b1;
    tick();

    // 8 bytes in ts0: one non-last word then a full last word
    for (int k = 1; k <= 8; k++) byte_in(8'(k), 1'b1, 1'b0);
    byte_win0 = 1'b0;
    tick();
    chk("t1_level", 36'(fifo_level), 36'(5'd2));
    pop_word("t1_w0", 32'h04030201, 1'b0, 1'b0, 2'd3);
    pop_word("t1_w1", 32'h08070605, 1'b0, 1'b1, 2'd3);

    // 6 bytes in ts1: full word then a 2-byte tail
    for (int k = 0; k < 6; k++) byte_in(8'hA0 + 8'(k), 1'b0, 1'b1);
    byte_win1 = 1'b0;
    tick();
    chk("t2_level", 36'(fifo_level), 36'(5'd2));
    pop_word("t2_w0", 32'hA3A2A1A0, 1'b1, 1'b0, 2'd3);
    pop_word("t2_w1", 32'h0000A5A4, 1'b1, 1'b1, 2'd1);

    // ts0 falls while ts1 rises with a byte: ts0 flush first, byte starts ts1 word
    byte_in(8'h11, 1'b1, 1'b0);
    byte_in(8'h22, 1'b1, 1'b0);
    byte_in(8'h33, 1'b0, 1'b1);
    byte_in(8'h44, 1'b0, 1'b1);
    byte_win1 = 1'b0;
    tick();
    chk("t3_level", 36'(fifo_level), 36'(5'd2));
    pop_word("t3_w0", 32'h00002211, 1'b0, 1'b1, 2'd1);
    pop_word("t3_w1", 32'h00004433, 1'b1, 1'b1, 2'd1);

    // ts0 byte while ts1 still open closes ts1
    byte_in(8'h66, 1'b0, 1'b1);
    byte_in(8'h77, 1'b1, 1'b1);
    byte_win0 = 1'b0;
    byte_win1 = 1'b0;
    tick();
    chk("t4_level", 36'(fifo_level), 36'(5'd2));
    pop_word("t4_w0", 32'h00000066, 1'b1, 1'b1, 2'd0);
    pop_word("t4_w1", 32'h00000077, 1'b0, 1'b1, 2'd0);

    // Single-byte window: byte at N, window last high at N+1, word valid at N+3
    byte_in(8'h5A, 1'b1, 1'b0);
    chk("lat_n1", 36'(wif.word_valid), 36'(1'b0));
    tick();
    byte_win0 = 1'b0;
    chk("lat_n2", 36'(wif.word_valid), 36'(1'b0));
    tick();
    chk("lat_n3", 36'(wif.word_valid), 36'(1'b1));
    pop_word("lat_w", 32'h0000005A, 1'b0, 1'b1, 2'd0);

    // 17 full words with no sink: 16 stored, the last (close flush) dropped
    for (int k = 0; k < 68; k++) byte_in(8'(k), 1'b1, 1'b0);
    byte_win0 = 1'b0;
    tick();
    chk("ovf_level", 36'(fifo_level), 36'(5'd16));
    chk("ovf_flag", 36'(ovf_flag), 36'(1'b1));
    chk_stats("ovf", 16'd21, 16'd4, 16'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 36'(ovf_flag), 36'(1'b0));

    // Full FIFO: push and pop in the same cycle keep the level at 16
    for (int k = 0; k < 4; k++) byte_in(8'hC0 + 8'(k), 1'b1, 1'b0);
    chk("pp_head", 36'(wif.word_data), 36'(32'h03020100));
    byte_win0 = 1'b0;
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    chk("pp_level", 36'(fifo_level), 36'(5'd16));
    chk("pp_ovf", 36'(ovf_flag), 36'(1'b0));
    chk_stats("pp", 16'd22, 16'd4, 16'd1);
    for (int w = 1; w < 16; w++) begin
      exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      pop_word($sformatf("drain%0d", w), exp_w, 1'b0, 1'b0, 2'd3);
    end
    pop_word("drain_c", 32'hC3C2C1C0, 1'b0, 1'b1, 2'd3);
    chk("drain_level", 36'(fifo_level), 36'(5'd0));

    // Pop on empty is ignored
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    chk("empty_pop_level", 36'(fifo_level), 36'(5'd0));

    // Reset mid-window after 3 bytes: everything cleared, nothing emitted later
    byte_in(8'h01, 1'b1, 1'b0);
    byte_in(8'h02, 1'b1, 1'b0);
    byte_in(8'h03, 1'b1, 1'b0);
    reset_n   = 1'b0;
    byte_win0 = 1'b0;
    #1;
    chk_idle("mrst");
    chk("mrst_ovf", 36'(ovf_flag), 36'(1'b0));
    chk_stats("mrst", 16'd0, 16'd0, 16'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/byte_pack_fifo.md
# byte_pack_fifo

Packs the byte stream produced by the LDPC bit-to-byte stage into 32-bit words tagged with timeslot ID and end-of-window marker, then buffers them in a small synchronous FIFO behind a valid/ready interface. It sits directly downstream of the bit-to-byte converter (consumes `byte_sync`, `byte_data`, `byte_win0`, `byte_win1`) and upstream of the bus/DMA writer that moves decoded timeslot data to memory.

## Interface
- `FIFO_DEPTH`, 16, number of FIFO entries; power of two, minimum 4.
- `LVL_W`, 5, width of `fifo_level`; equals log2(`FIFO_DEPTH`)+1.
- Clock and reset: one clock, `clk`; reset `reset_n` is asynchronous and active-low.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `byte_sync` in 1: one-cycle strobe, `byte_data` valid.
- `byte_data` in 8: byte; first-received bit in bit 0.
- `byte_win0` in 1: timeslot-0 byte window.
- `byte_win1` in 1: timeslot-1 byte window.
- `word_ready` in 1: sink accepts the head word.
- `ovf_clr` in 1: clears `ovf_flag`.
- `word_valid` out 1: FIFO non-empty; head word presented.
- `word_data` out 32: packed word; first byte in [7:0].
- `word_ts` out 1: timeslot of word (0/1).
- `word_last` out 1: final word of a window.
- `word_nbytes` out 2: valid bytes minus one (3 = full word).
- `fifo_level` out `LVL_W`: current occupancy.
- `ovf_flag` out 1: sticky, a FIFO write was dropped.
- `word_cnt0`, `word_cnt1` out 16: words pushed per timeslot (see Configuration).
- `drop_cnt` out 16: dropped words (see Configuration).

## Operation
- Byte accepted when `byte_sync`=1 and (`byte_win0`|`byte_win1`). ts = 0 if `byte_win0`=1, else 1 (ts0 wins if both high).
- Pack register: 32 bits, pack count 0..3, ts latch. Byte k of a word goes to bits [8k+7:8k].
- 4th byte moves the word to a pending register (pend_v=1), pack count returns to 0. Pend and a non-empty pack never coexist.
- Next byte accepted with same ts while pend_v=1: pend pushed with last=0, nbytes=3; byte enters pack slot 0.
- Window close: registered `win_q0`/`win_q1` (previous `byte_winX`). Close of ts X when `win_qX`=1, `byte_winX`=0 and latched ts = X. On close: pend_v → push pend, last=1, nbytes=3; else pack count>0 → push partial, last=1, nbytes=count-1, unused bytes zero; else no push. Pack and pend cleared.
- A byte of the other ts accepted in the close cycle starts a fresh pack after the flush; at most one push per cycle.
- A byte of a different ts while the old window is still open (both high): treated as close of the old ts, then the new byte starts.
- FIFO: 36-bit entries {ts, last, nbytes, data}, show-ahead. Pop when `word_valid`&`word_ready`. Push on full without pop: dropped, `ovf_flag` set. Push and pop same cycle when full: both take effect, level unchanged. Pop on empty ignored.
- `ovf_flag` cleared by `ovf_clr`; a drop in the same cycle as `ovf_clr` wins (flag stays 1).
- Pointers wrap modulo `FIFO_DEPTH`; level ranges 0..`FIFO_DEPTH`.

## Timing
- All outputs reset to 0; pack, pend, window registers and pointers reset to 0.
- Byte accepted cycle N → pack/pend updated at N+1.
- Push decision made in cycle C (next byte or close detection); `word_valid`/`fifo_level` reflect it at C+1.
- Close is detected the cycle after `byte_winX` falls, through `win_qX`.
- Minimum latency: window of 1 byte falling at cycle N+1 → `word_valid` at N+3.
- Reset mid-window discards pack, pend and FIFO contents; no partial word is emitted.

## Configuration
- `BYTE_PACK_STAT_EN` defined: `word_cnt0`/`word_cnt1` increment on each accepted push of ts0/ts1; `drop_cnt` increments per dropped push; all saturate at 16'hFFFF and are cleared by reset only.
- Not defined: the counter logic is not built and the three outputs are tied to 0.

## Test plan
- 8 bytes 0x01..0x08 in ts0 window with `word_ready`=1 → words 0x04030201 (last=0, nbytes=3), then 0x08070605 (last=1, nbytes=3, ts=0).
- 6 bytes 0xA0..0xA5 in ts1 → 0xA3A2A1A0 (last=0), then 0x0000A5A4 (last=1, nbytes=1, ts=1).
- ts0 window falls and ts1 rises the same cycle with a ts1 byte → ts0 flush pushed first; ts1 byte lands in slot 0 of the next word.
- `word_ready`=0, 17 full words pushed with `FIFO_DEPTH`=16 → `fifo_level`=16, `ovf_flag`=1, 17th lost; `drop_cnt`=1 with macro; `ovf_clr` → flag 0.
- Full FIFO with simultaneous pop and push → level stays 16, no overflow, order preserved.
- `reset_n` low after 3 bytes of an open window → all outputs 0, no word is produced after release.
